// File: rtl/encoder16x4_activelowin.sv
// Registered 16-to-4 priority encoder for active-low requests; 2-edge latency from d_n to y/valid.
// The captured code is held until ack; while held, new requests are ignored.
module encoder16x4_activelowin #(
  parameter int N  = 16,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_n,
  input  logic [N-1:0]  d_n,
  input  logic          ack,
  output logic [CW-1:0] y,
  output logic          valid,
  output logic          multi
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [N-1:0]  req_q;
  logic [CW-1:0] y_q, y_d;
  logic          valid_q, valid_d;
  logic          multi_q, multi_d;
  logic [CW-1:0] enc;
  logic          many;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q <= '0;
    end else begin
      req_q <= en_n ? '0 : ~d_n;
    end
  end

  // Last match wins, so the highest set index takes priority.
  always_comb begin
    enc = '0;
    for (int i = 0; i < N; i++) begin
      if (req_q[i]) begin
        enc = CW'(i);
      end
    end
  end

  // More than one bit set iff clearing the lowest set bit leaves something behind.
  assign many = (req_q & (req_q - ONE)) != '0;

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    valid_d = valid_q;
    multi_d = multi_q;
    case (state_q)
      IDLE: begin
        if (|req_q) begin
          y_d     = enc;
          multi_d = many;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (ack) begin
          y_d     = '0;
          multi_d = 1'b0;
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= '0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
    end
  end

  assign y     = y_q;
  assign valid = valid_q;
  assign multi = multi_q;

endmodule

// File: doc/encoder16x4_activelowin.md
Name: encoder16x4_activelowin

Overview:
Registered 16-to-4 priority encoder for active-low request lines. It is the inverse of the team's active-low-output 4x16 decoder and closes the loop with it.
- Samples 16 active-low request lines and encodes the highest-index asserted line to a 4-bit code.
- Holds the code with a valid flag until the consumer acknowledges it.
- Used as the return path for decoder-driven select lines and as the front end for button and interrupt banks.

Parameters:
N, 16, number of request lines (fixed at 16 for this revision)
CW, 4, code width, equal to log2(N)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
en_n  input  1  active-low enable; 1 masks all requests at the sample stage
d_n  input  16  request lines, active-low (bit i low = request i)
ack  input  1  consumer acknowledge; meaningful only while valid=1
y  output  4  encoded index of highest asserted request
valid  output  1  y holds a captured, unacknowledged code
multi  output  1  more than one request was asserted in the captured sample

Behaviour:
- Reset and clocking: one clock domain. Reset is synchronous and active-high.
- Stage 1, sample register req_q[15:0]:
  - Every edge, req_q <= (en_n==0) ? ~d_n : 16'h0000.
  - req_q updates in every state.
- Stage 2, FSM with two states, IDLE and HOLD.
- IDLE:
  - If |req_q at an edge: y <= index of highest set bit of req_q (bit 15 has top priority), multi <= (popcount(req_q) > 1), valid <= 1, state <= HOLD.
  - Otherwise outputs are unchanged and valid stays 0.
- HOLD:
  - y, multi and valid are frozen. req_q changes are ignored.
  - ack=1 at an edge: valid <= 0, multi <= 0, y <= 0, state <= IDLE.
- Latency: a d_n change at edge N shows on y/valid after edge N+1 (2 edges) when the FSM is in IDLE.
- Back-to-back captures:
  - After an ack, valid is low for at least 1 cycle.
  - A request still present is re-encoded at the next edge. A steady request therefore produces valid 1, then 0 for one cycle, then 1 again.
- Boundary conditions:
  - ack in IDLE: ignored, no state change.
  - ack and a new request at the same edge in HOLD: ack wins and the FSM goes to IDLE. The request is encoded at the following edge.
  - en_n rising while in HOLD: the held code is not aborted. Only future samples are masked.
  - All d_n high (16'hFFFF): no capture. y=0 with valid=0 means "no request"; y=0 with valid=1 means request 0.
  - d_n = 16'h0000 (all asserted): y=15, multi=1.
  - ack held high continuously: captures alternate, valid for 1 cycle then low for 1 cycle.
  - X/Z on d_n: not handled; treated as a bench error.
- Reset:
  - rst=1 at an edge: req_q=0, y=0, valid=0, multi=0, state=IDLE. This applies mid-HOLD as well, and the held code is dropped.
  - rst has priority over ack and over new requests.
  - First possible capture is 2 edges after rst deasserts.

Test Plan:
- Single line: rst 2 cycles, en_n=0, d_n=16'hFFF7 -> after 2 edges y=4'd3, valid=1, multi=0. Then ack=1 for 1 cycle -> valid=0, y=0, followed by a recapture y=3 one cycle later.
- Priority sweep: d_n = ~(1<<i) for i=0..15, each acked -> y=i, multi=0 each time. Then d_n=16'h7FFE -> y=15, multi=1. Then d_n=16'h0000 -> y=15, multi=1.
- Enable masking: en_n=1 with d_n=16'h0000 for 10 cycles -> valid stays 0, y=0. Drop en_n to 0 -> y=15 and valid=1 2 edges later.
- Hold stability: capture bit 3, then change d_n to 16'hFFDF (bit 5) without ack for 8 cycles -> y stays 3, valid=1. Ack -> valid=0 for 1 cycle, then y=5, valid=1.
- Simultaneous events: in HOLD, ack=1 on the same edge d_n changes to bit 9 -> IDLE for 1 cycle, then y=9. ack=1 while in IDLE -> no change.
- Reset mid-operation: rst=1 while valid=1, y=12 -> next edge y=0, valid=0, multi=0. With d_n held at bit 12 and rst released, valid rises again exactly 2 edges later with y=12.
